// File: rtl/scrambler_core_pkg.sv
// Shared definitions for the Gold-sequence bit scrambler: FSM states, tag codes,
// default generator warm-up length and the data scrambling helper.
package scrambler_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_FLUSH  = 3'd4
  } scr_state_e;

  localparam logic [1:0] TAG_DATA = 2'b00;
  localparam logic [1:0] TAG_X    = 2'b01;
  localparam logic [1:0] TAG_Y    = 2'b10;

  localparam int NC_SHIFT_DEFAULT = 1600;

  function automatic logic scr_data_bit(input logic data_bit, input logic gold_bit);
    return data_bit ^ gold_bit;
  endfunction

endpackage

// File: rtl/scrambler_core_scr_out_reg.sv
// One-entry output register with valid/ready; loads on accept, holds under
// back-pressure and empties when consumed without a refill.
module scr_out_reg (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic bit_i,
  input  logic last_i,
  input  logic ready_i,
  output logic valid_o,
  output logic data_o,
  output logic last_o
);

  logic valid_q;
  logic data_q;
  logic last_q;

  // A load always wins: upstream only loads when the slot is empty or draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= bit_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_q;
      last_q  <= last_q;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/scrambler_core.sv
// Codeword scrambler driving an external Gold generator (load, warm-up, run).
// Optional x/y marker-bit tag handling is selected by a configuration macro.
module scrambler_core
  import scrambler_core_pkg::*;
#(
  parameter int NC_SHIFT = NC_SHIFT_DEFAULT,
  parameter int LEN_W    = 17
) (
  input  logic             CLK_SCR,
  input  logic             RST_SCR,
  input  logic             START,
  input  logic [LEN_W-1:0] NUM_BITS,
  input  logic             DATA_IN,
  input  logic [1:0]       DATA_TAG,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  input  logic             GOLD_SEQ,
  input  logic             GOLD_VALID,
  output logic             PR_EN,
  output logic             PR_SHIFT,
  output logic             PR_OUT_EN,
  output logic             PR_BUSY,
  output logic             SCR_OUT,
  output logic             SCR_VALID,
  output logic             SCR_LAST,
  input  logic             SCR_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT
);

  localparam int WCNT_W = $clog2(NC_SHIFT + 6);
  localparam logic [WCNT_W-1:0] WARM_LIMIT = WCNT_W'(NC_SHIFT + 4);

  scr_state_e        state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bcnt_q;
  logic [LEN_W-1:0]  bcnt_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic              pr_en_q;
  logic              pr_shift_q;
  logic              pr_out_en_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic              accept_s;
  logic              last_s;
  logic              out_bit_s;

  assign DATA_READY = (state_q == ST_RUN) & (~SCR_VALID | SCR_READY);
  assign accept_s   = DATA_VALID & DATA_READY;
  assign PR_BUSY    = accept_s;
  assign bcnt_d     = bcnt_q + LEN_W'(1);
  assign last_s     = (bcnt_d == len_q);

`ifdef SCR_PLACEHOLDER_EN
  logic prev_q;

  always_comb begin
    out_bit_s = scr_data_bit(DATA_IN, GOLD_SEQ);
    case (DATA_TAG)
      TAG_X:   out_bit_s = 1'b1;
      TAG_Y:   out_bit_s = prev_q;
      default: out_bit_s = scr_data_bit(DATA_IN, GOLD_SEQ);
    endcase
  end

  // Cleared while idle so a leading y marker bit repeats 0.
  always_ff @(posedge CLK_SCR or negedge RST_SCR) begin
    if (!RST_SCR) begin
      prev_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      prev_q <= 1'b0;
    end else if (accept_s) begin
      prev_q <= out_bit_s;
    end else begin
      prev_q <= prev_q;
    end
  end
`else
  logic unused_tag_s;
  assign unused_tag_s = ^DATA_TAG;
  assign out_bit_s    = scr_data_bit(DATA_IN, GOLD_SEQ);
`endif

  always_ff @(posedge CLK_SCR or negedge RST_SCR) begin
    if (!RST_SCR) begin
      state_q     <= ST_IDLE;
      len_q       <= {LEN_W{1'b0}};
      bcnt_q      <= {LEN_W{1'b0}};
      wcnt_q      <= {WCNT_W{1'b0}};
      pr_en_q     <= 1'b0;
      pr_shift_q  <= 1'b0;
      pr_out_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            if (NUM_BITS != {LEN_W{1'b0}}) begin
              state_q     <= ST_LOAD;
              len_q       <= NUM_BITS;
              bcnt_q      <= {LEN_W{1'b0}};
              wcnt_q      <= {WCNT_W{1'b0}};
              pr_en_q     <= 1'b1;
              pr_shift_q  <= 1'b0;
              pr_out_en_q <= 1'b0;
              busy_q      <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state_q    <= ST_WARMUP;
          pr_shift_q <= 1'b1;
        end
        ST_WARMUP: begin
          wcnt_q <= wcnt_q + WCNT_W'(1);
          if (GOLD_VALID) begin
            state_q     <= ST_RUN;
            pr_shift_q  <= 1'b0;
            pr_out_en_q <= 1'b1;
          end else if (wcnt_q == WARM_LIMIT) begin
            // Generator never came up: abandon the codeword without DONE.
            state_q    <= ST_IDLE;
            pr_en_q    <= 1'b0;
            pr_shift_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            bcnt_q <= bcnt_d;
            if (last_s) begin
              state_q     <= ST_FLUSH;
              pr_en_q     <= 1'b0;
              pr_out_en_q <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (SCR_VALID && SCR_READY) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          pr_en_q     <= 1'b0;
          pr_shift_q  <= 1'b0;
          pr_out_en_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign PR_EN     = pr_en_q;
  assign PR_SHIFT  = pr_shift_q;
  assign PR_OUT_EN = pr_out_en_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign TIMEOUT   = timeout_q;

  scr_out_reg u_out_reg (
    .clk_i   (CLK_SCR),
    .rst_ni  (RST_SCR),
    .load_i  (accept_s),
    .bit_i   (out_bit_s),
    .last_i  (last_s),
    .ready_i (SCR_READY),
    .valid_o (SCR_VALID),
    .data_o  (SCR_OUT),
    .last_o  (SCR_LAST)
  );

endmodule

// File: tb/tb_scrambler_core.sv
// Bench for scrambler_core with a Gold generator (c_init=0x1234) and a
// recurrence-based reference sequence feeding an output scoreboard.
module tb_scrambler_core;

  localparam int NC    = 1600;
  localparam int LEN_W = 17;
  localparam logic [30:0] CINIT = 31'h0000_1234;

  logic             CLK_SCR    = 1'b0;
  logic             RST_SCR    = 1'b0;
  logic             START      = 1'b0;
  logic [LEN_W-1:0] NUM_BITS   = '0;
  logic             DATA_IN    = 1'b0;
  logic [1:0]       DATA_TAG   = 2'b00;
  logic             DATA_VALID = 1'b0;
  logic             DATA_READY;
  logic             GOLD_SEQ;
  logic             GOLD_VALID;
  logic             PR_EN, PR_SHIFT, PR_OUT_EN, PR_BUSY;
  logic             SCR_OUT, SCR_VALID, SCR_LAST;
  logic             SCR_READY  = 1'b1;
  logic             BUSY, DONE, TIMEOUT;

  int checks = 0, errors = 0;
  int done_cnt = 0, to_cnt = 0, busy_cnt = 0;
  logic [1:0] exp_q[$];
  bit   x1a[0:NC+99];
  bit   x2a[0:NC+99];
  bit   c_ref[0:63];
  bit   din_a[0:63];
  logic [1:0] tag_a[0:63];

  always #5 CLK_SCR = ~CLK_SCR;

  scrambler_core #(.NC_SHIFT(NC), .LEN_W(LEN_W)) dut (
    .CLK_SCR(CLK_SCR), .RST_SCR(RST_SCR), .START(START), .NUM_BITS(NUM_BITS),
    .DATA_IN(DATA_IN), .DATA_TAG(DATA_TAG), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .GOLD_SEQ(GOLD_SEQ), .GOLD_VALID(GOLD_VALID),
    .PR_EN(PR_EN), .PR_SHIFT(PR_SHIFT), .PR_OUT_EN(PR_OUT_EN), .PR_BUSY(PR_BUSY),
    .SCR_OUT(SCR_OUT), .SCR_VALID(SCR_VALID), .SCR_LAST(SCR_LAST), .SCR_READY(SCR_READY),
    .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT)
  );

  // Gold generator: load c_init, NC warm-up shifts, then one shift per PR_BUSY.
  logic [30:0] gx1, gx2;
  int          gcnt;
  logic        gold_kill = 1'b0;
  always @(posedge CLK_SCR or negedge RST_SCR) begin
    if (!RST_SCR) begin
      gx1 <= '0; gx2 <= '0; gcnt <= 0;
    end else if (PR_EN && !PR_SHIFT && !PR_OUT_EN) begin
      gx1 <= 31'd1; gx2 <= CINIT; gcnt <= 0;
    end else if ((PR_EN && PR_SHIFT && gcnt < NC) || PR_BUSY) begin
      gx1 <= {gx1[3] ^ gx1[0], gx1[30:1]};
      gx2 <= {gx2[3] ^ gx2[2] ^ gx2[1] ^ gx2[0], gx2[30:1]};
      if (PR_SHIFT) gcnt <= gcnt + 1;
    end
  end
  assign GOLD_VALID = (gcnt == NC) && !gold_kill;
  assign GOLD_SEQ   = gx1[0] ^ gx2[0];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: output scoreboard, back-pressure hold rule, event counters.
  initial begin : mon
    logic       hold_pend, hold_bit;
    logic [1:0] e;
    hold_pend = 1'b0; hold_bit = 1'b0;
    forever begin
      @(negedge CLK_SCR);
      if (!RST_SCR) begin
        hold_pend = 1'b0;
      end else begin
        if (DONE)    done_cnt++;
        if (TIMEOUT) to_cnt++;
        if (PR_BUSY) busy_cnt++;
        if (hold_pend) chk("hold_out", {14'd0, SCR_VALID, SCR_OUT}, {14'd0, 1'b1, hold_bit});
        if (SCR_VALID && !SCR_READY) begin
          chk("stall_data_ready", {15'd0, DATA_READY}, 16'd0);
          hold_pend = 1'b1; hold_bit = SCR_OUT;
        end else begin
          hold_pend = 1'b0;
        end
        if (SCR_VALID && SCR_READY) begin
          if (exp_q.size() == 0) chk("spurious_out", {15'd0, SCR_VALID}, 16'd0);
          else begin
            e = exp_q.pop_front();
            chk("scr_out_last", {14'd0, SCR_LAST, SCR_OUT}, {14'd0, e});
          end
        end
      end
    end
  end

  task automatic pulse_start(input int n);
    @(posedge CLK_SCR); #1; START = 1'b1; NUM_BITS = LEN_W'(n);
    @(posedge CLK_SCR); #1; START = 1'b0;
  endtask

  // Sends din_a/tag_a[0..n-1]; optional 3-cycle output stall or reset abort.
  task automatic send_cw(input int n, input int stall_at, input int abort_after);
    logic e, prev;
    int idx, cyc, first_acc, last_acc, stall_left, b0, d0;
    bit acc, stalled;
    prev = 1'b0;
    for (int i = 0; i < n; i++) begin
`ifdef SCR_PLACEHOLDER_EN
      if (tag_a[i] == 2'b01)      e = 1'b1;
      else if (tag_a[i] == 2'b10) e = prev;
      else                        e = din_a[i] ^ c_ref[i];
`else
      e = din_a[i] ^ c_ref[i];
`endif
      prev = e;
      exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, e});
    end
    b0 = busy_cnt; d0 = done_cnt;
    pulse_start(n);
    @(negedge CLK_SCR);
    chk("load_ctrl", {12'd0, PR_EN, PR_SHIFT, PR_OUT_EN, BUSY}, 16'h9);
    @(negedge CLK_SCR);
    chk("warm_ctrl", {12'd0, PR_EN, PR_SHIFT, PR_OUT_EN, BUSY}, 16'hD);
    idx = 0; cyc = 0; first_acc = -1; last_acc = -1; stall_left = 0; stalled = 0;
    DATA_VALID = 1'b1; DATA_IN = din_a[0]; DATA_TAG = tag_a[0];
    while (idx < n && cyc < 4000) begin
      @(negedge CLK_SCR);
      acc = DATA_VALID && DATA_READY;
      if (acc && idx == 0) chk("run_ctrl", {13'd0, PR_EN, PR_SHIFT, PR_OUT_EN}, 16'h5);
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      @(posedge CLK_SCR); #1; cyc++;
      if (acc) idx++;
      if (idx < n) begin DATA_IN = din_a[idx]; DATA_TAG = tag_a[idx]; end
      if (idx == stall_at && !stalled) begin
        SCR_READY = 1'b0; stall_left = 3; stalled = 1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) SCR_READY = 1'b1;
      end
      if (abort_after > 0 && idx == abort_after) begin
        RST_SCR = 1'b0; DATA_VALID = 1'b0; SCR_READY = 1'b1;
        #1;
        chk("abort_outputs_zero",
            {5'd0, DATA_READY, PR_EN, PR_SHIFT, PR_OUT_EN, PR_BUSY, SCR_OUT, SCR_VALID,
             SCR_LAST, BUSY, DONE, TIMEOUT}, 16'd0);
        exp_q.delete();
        repeat (3) @(negedge CLK_SCR);
        chk("abort_no_done", 16'(done_cnt - d0), 16'd0);
        RST_SCR = 1'b1;
        return;
      end
    end
    DATA_VALID = 1'b0;
    chk("all_bits_accepted", 16'(idx), 16'(n));
    if (stall_at < 0) chk("full_throughput", 16'(last_acc - first_acc + 1), 16'(n));
    @(negedge CLK_SCR);
    chk("flush_ctrl", {10'd0, PR_EN, PR_SHIFT, PR_OUT_EN, PR_BUSY, DATA_READY, BUSY}, 16'h1);
    SCR_READY = 1'b1;
    cyc = 0;
    while (done_cnt == d0 && cyc < 50) begin
      @(negedge CLK_SCR); #2; cyc++;
    end
    chk("done_pulse", 16'(done_cnt - d0), 16'd1);
    chk("idle_after_done", {15'd0, BUSY}, 16'd0);
    chk("pr_busy_pulses", 16'(busy_cnt - b0), 16'(n));
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int sh, d0, t0;
    bit seen;
    logic [11:0] pat;
    // Reference sequence straight from the Gold recurrences.
    for (int i = 0; i < 31; i++) begin
      x1a[i] = (i == 0);
      x2a[i] = CINIT[i];
    end
    for (int n = 0; n + 31 < NC + 100; n++) begin
      x1a[n+31] = x1a[n+3] ^ x1a[n];
      x2a[n+31] = x2a[n+3] ^ x2a[n+2] ^ x2a[n+1] ^ x2a[n];
    end
    for (int i = 0; i < 64; i++) c_ref[i] = x1a[i+NC] ^ x2a[i+NC];
    chk("pin_x1_31", {15'd0, x1a[31]}, 16'd1);
    chk("pin_x1_59", {15'd0, x1a[59]}, 16'd1);
    chk("pin_x2_31", {15'd0, x2a[31]}, 16'd1);
    chk("pin_x2_32", {15'd0, x2a[32]}, 16'd0);

    #1;
    chk("reset_outputs_zero",
        {5'd0, DATA_READY, PR_EN, PR_SHIFT, PR_OUT_EN, PR_BUSY, SCR_OUT, SCR_VALID,
         SCR_LAST, BUSY, DONE, TIMEOUT}, 16'd0);
    repeat (3) @(posedge CLK_SCR);
    @(negedge CLK_SCR); RST_SCR = 1'b1;

    // Zero-length request completes at once.
    pulse_start(0);
    @(negedge CLK_SCR);
    chk("zero_len_done", {14'd0, DONE, BUSY}, 16'h2);
    @(negedge CLK_SCR);
    chk("zero_len_done_pulse", {14'd0, DONE, BUSY}, 16'h0);

    for (int i = 0; i < 64; i++) begin din_a[i] = 1'b0; tag_a[i] = 2'b00; end
    send_cw(8, -1, 0);
    for (int i = 0; i < 8; i++) din_a[i] = 1'b1;
    send_cw(8, -1, 0);

    // Placeholders: x/y bits still consume one generator bit each.
    din_a[0] = 1'b1; din_a[1] = 1'b0; din_a[2] = 1'b0; din_a[3] = 1'b0; din_a[4] = 1'b0;
    tag_a[0] = 2'b00; tag_a[1] = 2'b01; tag_a[2] = 2'b10; tag_a[3] = 2'b10; tag_a[4] = 2'b00;
    send_cw(5, -1, 0);

    pat = 12'hA5C;
    for (int i = 0; i < 12; i++) begin din_a[i] = pat[i]; tag_a[i] = 2'b00; end
    send_cw(12, 5, 0);

    // Generator never valid: TIMEOUT after NC+5 warm-up cycles, no DONE.
    gold_kill = 1'b1;
    d0 = done_cnt; t0 = to_cnt; sh = 0; seen = 0;
    pulse_start(4);
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge CLK_SCR);
      if (PR_SHIFT) sh++;
      if (TIMEOUT) begin
        seen = 1;
        chk("timeout_busy_low", {15'd0, BUSY}, 16'd0);
      end
    end
    chk("timeout_seen", {15'd0, seen}, 16'd1);
    chk("timeout_warm_cycles", 16'(sh), 16'(NC + 5));
    @(negedge CLK_SCR); #2;
    chk("timeout_pulse_width", {15'd0, TIMEOUT}, 16'd0);
    chk("timeout_count", 16'(to_cnt - t0), 16'd1);
    chk("timeout_no_done", 16'(done_cnt - d0), 16'd0);
    gold_kill = 1'b0;

    // Reset after 3 of 8 bits, then a clean 4-bit codeword.
    for (int i = 0; i < 8; i++) din_a[i] = i[0];
    send_cw(8, -1, 3);
    for (int i = 0; i < 4; i++) din_a[i] = ~i[1];
    send_cw(4, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
